// File: rtl/sobel_stream_engine.sv
// Streaming 3x3 Sobel edge engine: valid/ready pixel stream in, one result per input pixel out,
// in raster order, using two line buffers and a sliding window.
module sobel_stream_engine #(
  parameter int PIXEL_WIDTH = 8,
  parameter int IMG_WIDTH   = 640,
  parameter int IMG_HEIGHT  = 480
) (
  input  logic                   sobel_clk_i,
  input  logic                   nreset_i,
  input  logic [1:0]             mode_i,
  input  logic [PIXEL_WIDTH-1:0] threshold_i,
  input  logic                   px_valid_i,
  output logic                   px_ready_o,
  input  logic [PIXEL_WIDTH-1:0] px_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [PIXEL_WIDTH-1:0] out_data_o,
  output logic                   frame_done_o,
  output logic                   busy_o
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int FW = $clog2(IMG_WIDTH + 2);
  localparam int SW = PIXEL_WIDTH + 4;
  localparam logic [SW-1:0] MAXV = SW'((2 ** PIXEL_WIDTH) - 1);

  localparam logic [1:0] ST_FILL   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_FLUSH  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]             state;
  logic                   started;
  logic [CW-1:0]          col;
  logic [RW-1:0]          row;
  logic [FW-1:0]          flush_cnt;
  logic [1:0]             mode_r;
  logic [PIXEL_WIDTH-1:0] thr_r;
  logic [PIXEL_WIDTH-1:0] win_a [3];
  logic [PIXEL_WIDTH-1:0] win_b [3];
  logic [PIXEL_WIDTH-1:0] ncol  [3];
  logic [PIXEL_WIDTH-1:0] lb0   [IMG_WIDTH];
  logic [PIXEL_WIDTH-1:0] lb1   [IMG_WIDTH];

  logic accept, out_fire, last_col, last_row, border;
  logic [SW-1:0] gx, gy, ax, ay, sum;
  logic [PIXEL_WIDTH-1:0] result;

  function automatic logic [PIXEL_WIDTH-1:0] sat(input logic [SW-1:0] v);
    return (v > MAXV) ? '1 : v[PIXEL_WIDTH-1:0];
  endfunction

  assign accept       = px_valid_i && px_ready_o;
  assign out_fire     = out_valid_o && out_ready_i;
  assign last_col     = (col == CW'(IMG_WIDTH - 1));
  assign last_row     = (row == RW'(IMG_HEIGHT - 1));
  assign frame_done_o = (state == ST_DONE);
  // Window centre lags the incoming pixel by one row and one column.
  assign border       = (row == RW'(1)) || (col <= CW'(1));

  always_comb begin
    case (state)
      ST_FILL:   px_ready_o = started;
      ST_STREAM: px_ready_o = !out_valid_o || out_ready_i;
      default:   px_ready_o = 1'b0;
    endcase
  end

  always_comb begin
    ncol[0] = lb0[col];
    ncol[1] = lb1[col];
    ncol[2] = px_data_i;
    gx = (SW'(ncol[0]) + (SW'(ncol[1]) << 1) + SW'(ncol[2]))
       - (SW'(win_a[0]) + (SW'(win_a[1]) << 1) + SW'(win_a[2]));
    gy = (SW'(win_a[2]) + (SW'(win_b[2]) << 1) + SW'(ncol[2]))
       - (SW'(win_a[0]) + (SW'(win_b[0]) << 1) + SW'(ncol[0]));
    ax  = gx[SW-1] ? (~gx + SW'(1)) : gx;
    ay  = gy[SW-1] ? (~gy + SW'(1)) : gy;
    sum = ax + ay;
    case (mode_r)
      2'd0:    result = sat(sum);
      2'd1:    result = (sum >= SW'(thr_r)) ? '1 : '0;
      2'd2:    result = sat(ax);
      default: result = sat(ay);
    endcase
  end

  // Line buffers hold no reset: every location is written before it is read.
  always_ff @(posedge sobel_clk_i) begin
    if (accept) begin
      lb0[col] <= lb1[col];
      lb1[col] <= px_data_i;
    end
  end

  always_ff @(posedge sobel_clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state       <= ST_FILL;
      started     <= 1'b0;
      col         <= '0;
      row         <= '0;
      flush_cnt   <= '0;
      mode_r      <= '0;
      thr_r       <= '0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      busy_o      <= 1'b0;
      for (int unsigned i = 0; i < 3; i++) begin
        win_a[i] <= '0;
        win_b[i] <= '0;
      end
    end else begin
      started <= 1'b1;
      if (accept) begin
        busy_o <= 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
          win_a[i] <= win_b[i];
          win_b[i] <= ncol[i];
        end
        if (state == ST_FILL && col == '0 && row == '0) begin
          mode_r <= mode_i;
          thr_r  <= threshold_i;
        end
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
      case (state)
        ST_FILL: begin
          if (accept && row == RW'(1) && col == '0) state <= ST_STREAM;
        end
        ST_STREAM: begin
          if (accept) begin
            out_valid_o <= 1'b1;
            out_data_o  <= border ? '0 : result;
            if (last_row && last_col) state <= ST_FLUSH;
          end else if (out_fire) begin
            out_valid_o <= 1'b0;
          end
        end
        ST_FLUSH: begin
          if (flush_cnt == FW'(IMG_WIDTH + 1)) begin
            if (out_fire) begin
              out_valid_o <= 1'b0;
              busy_o      <= 1'b0;
              state       <= ST_DONE;
            end
          end else if (!out_valid_o || out_ready_i) begin
            out_valid_o <= 1'b1;
            out_data_o  <= '0;
            flush_cnt   <= flush_cnt + FW'(1);
          end
        end
        default: begin
          col       <= '0;
          row       <= '0;
          flush_cnt <= '0;
          state     <= ST_FILL;
        end
      endcase
    end
  end

endmodule

// File: doc/sobel_stream_engine.md
Name: sobel_stream_engine

Overview:
Parametrised streaming Sobel edge engine. It replaces the address-driven, one-pixel-per-many-cycles sobel_control flow with a valid/ready pixel stream that runs at up to one pixel per clock. Two internal line buffers and a 3x3 window compute Gx/Gy. Four selectable output modes: magnitude, thresholded binary, |Gx|, |Gy|. It sits between the grayscale source and the output frame sink, and emits exactly one result pixel per input pixel, in raster order.

Parameters:
PIXEL_WIDTH, 8, bits per grayscale and result pixel
IMG_WIDTH, 640, pixels per row (min 3)
IMG_HEIGHT, 480, rows per frame (min 3)

Ports:
sobel_clk_i  in  1  clock
nreset_i  in  1  reset, asynchronous, active-low
mode_i  in  2  0=|Gx|+|Gy| saturated, 1=binary threshold, 2=|Gx| saturated, 3=|Gy| saturated
threshold_i  in  PIXEL_WIDTH  threshold for mode 1
px_valid_i  in  1  input pixel valid
px_ready_o  out  1  engine accepts pixel this cycle
px_data_i  in  PIXEL_WIDTH  grayscale pixel, raster order
out_valid_o  out  1  result valid
out_ready_i  in  1  sink accepts result
out_data_o  out  PIXEL_WIDTH  result pixel
frame_done_o  out  1  one-cycle pulse after last result of a frame is accepted
busy_o  out  1  high from first accepted pixel until frame_done_o

Behaviour:
- Reset (async, nreset_i low) clears everything. Outputs go to: px_ready_o=0, out_valid_o=0, out_data_o=0, frame_done_o=0, busy_o=0. All counters, window registers and state are cleared to FILL. Line-buffer contents are don't-care because they are never read before being written.
- After reset release, px_ready_o rises on the first clock edge.
- Accept: a pixel is taken on a rising edge when px_valid_i && px_ready_o. An output transfer occurs when out_valid_o && out_ready_i.
- mode_i and threshold_i are registered when the first pixel of a frame is accepted. They are held for the whole frame, so changes mid-frame have no effect.
- Output pixel k is raster position (r,c) of the frame.
- Border positions output 0 in every mode: r=0, r=IMG_HEIGHT-1, c=0, c=IMG_WIDTH-1.
- Interior positions, with window p[i][j] taken from rows r-1..r+1 and cols c-1..c+1:
  - Gx = (p02+2p12+p22) - (p00+2p10+p20)
  - Gy = (p20+2p21+p22) - (p00+2p01+p02)
  - Both are signed, PIXEL_WIDTH+4 bits wide, so no overflow is possible.
- Mode results:
  - Modes 0, 2 and 3 saturate to 2^PIXEL_WIDTH-1.
  - Mode 1 outputs all-ones if (|Gx|+|Gy|) >= threshold, else 0.
- State machine:
  - FILL: the first IMG_WIDTH+1 accepts of a frame produce no output. px_ready_o=1. The (IMG_WIDTH+1)th accept moves to STREAM.
  - STREAM: each accept of input index n produces output index n-(IMG_WIDTH+1), registered on the same edge (output valid one cycle after accept).
    - px_ready_o = !out_valid_o || out_ready_i. The output register is never overwritten while holding an unconsumed value.
    - The accept of the last input (index IMG_WIDTH*IMG_HEIGHT-1) moves to FLUSH.
  - FLUSH: px_ready_o=0. Emit the remaining IMG_WIDTH+1 outputs, all border, therefore 0, one per out_valid_o/out_ready_i handshake. The final handshake moves to DONE.
  - DONE: one cycle. frame_done_o=1, busy_o drops, counters clear. Next cycle returns to FILL.
- Backpressure: out_ready_i low stalls the whole pipeline. No pixel is lost or duplicated, and out_data_o stays stable while out_valid_o && !out_ready_i.
- Throughput: with continuous valid and ready, one result per clock in STREAM.
- Row and column counters wrap at IMG_WIDTH-1 and IMG_HEIGHT-1. Line buffers are addressed by the column counter with read-before-write.
- An async reset mid-frame discards the partial frame. The next accepted pixel is treated as (0,0) of a new frame.

Test Plan:
- IMG_WIDTH=IMG_HEIGHT=4, every pixel 0x80, mode 0 -> 16 outputs all 0x00, frame_done_o pulses once after output 15, busy_o low afterwards.
- 4x4, each row 00,00,FF,FF, mode 0 -> interior (1,1),(1,2),(2,1),(2,2) = 0xFF (Gx=1020 saturated), border 0x00; mode 3 -> all 0x00; mode 2 -> same as mode 0.
- 4x4, each row 00,0A,14,1E, mode 0 -> interior 0x50 (Gx=80, Gy=0); mode 1 with threshold 0x64 -> interior 0x00; threshold 0x50 -> interior 0xFF.
- 4x4, continuous px_valid_i, out_ready_i low for 5 cycles after output 3 -> px_ready_o low during the stall, out_data_o held, final 16-output sequence identical to the no-stall run.
- Assert nreset_i low after 7 accepts, release, then stream a full ramp frame -> every output low while in reset, next frame matches the ramp expectations, exactly 16 outputs.
- Two back-to-back frames, mode_i changed from 0 to 3 mid-frame 1 -> frame 1 all mode 0, frame 2 all mode 3, px_ready_o=0 throughout FLUSH, two frame_done_o pulses.
